// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample feeder: sample width,
// feeder state encoding and the PCM silence value.
package audio_pkg;

   localparam int SAMPLE_W = 16;

   // FILL: priming the buffer, requests answered with silence.
   // RUN : requests pop the buffer head.
   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } feed_state_t;

   localparam logic [SAMPLE_W-1:0] PCM_ZERO = '0;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an unregistered (combinational) head read.
// push/pop must already be qualified by the caller against full/empty.
module sync_fifo
   import audio_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              push,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [AW:0]       level,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_level;

   // Sample storage; data path carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= r_level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign level = r_level;
   assign full  = (r_level == (AW+1)'(DEPTH));
   assign empty = (r_level == '0);

endmodule

// File: rtl/audio_sample_feeder.sv
// Sample buffer feeding the I2S DAC serializer. Buffers mixer samples,
// primes to PRIME_LEVEL before playing, answers each serializer request
// with the next sample and flags underruns stickily.
// Optional macro ATTEN_EN: arithmetic right-shift of each popped sample
// by the atten input; without it atten is ignored.
module audio_sample_feeder
   import audio_pkg::*;
#(
   parameter int DATA_W      = SAMPLE_W,
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int PRIME_LEVEL = 8
) (
   input  logic              clk_50m,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              sample_req,
   output logic [DATA_W-1:0] wav_data,
   output logic [AW:0]       level,
   output logic              underrun,
   input  logic              underrun_clr,
   input  logic [3:0]        atten
);

   feed_state_t       r_state;
   logic [DATA_W-1:0] r_wav;
   logic              r_underrun;

   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_head;
   logic [DATA_W-1:0] w_sample;
   logic [AW:0]       w_level;

`ifdef ATTEN_EN
   // Sign-preserving attenuation; a shift of 15 leaves only the sign.
   function automatic logic [DATA_W-1:0] apply_atten(input logic [DATA_W-1:0] w,
                                                     input logic [3:0]        sh);
      return DATA_W'($signed(w) >>> sh);
   endfunction

   assign w_sample = apply_atten(w_head, atten);
`else
   logic w_unused_atten;
   assign w_unused_atten = ^atten;
   assign w_sample       = w_head;
`endif

   // full is derived from the registered level, so s_ready is too.
   assign s_ready = !w_full;
   assign w_push  = s_valid && s_ready;
   assign w_pop   = sample_req && (r_state == RUN) && !w_empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_fifo (
      .clk   (clk_50m),
      .rst   (rst),
      .din   (s_data),
      .push  (w_push),
      .pop   (w_pop),
      .dout  (w_head),
      .level (w_level),
      .full  (w_full),
      .empty (w_empty)
   );

   // Prime/refill FSM with registered output sample and sticky underrun.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_state    <= FILL;
         r_wav      <= DATA_W'(PCM_ZERO);
         r_underrun <= 1'b0;
      end else begin
         // Clear first so a same-cycle underrun below overrides it.
         if (underrun_clr) begin
            r_underrun <= 1'b0;
         end
         unique case (r_state)
            FILL: begin
               if (sample_req) begin
                  r_wav <= DATA_W'(PCM_ZERO);
               end
               if (w_level >= (AW+1)'(PRIME_LEVEL)) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (sample_req) begin
                  if (!w_empty) begin
                     r_wav <= w_sample;
                  end else begin
                     r_wav      <= DATA_W'(PCM_ZERO);
                     r_underrun <= 1'b1;
                     r_state    <= FILL;
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign wav_data = r_wav;
   assign level    = w_level;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: reference model plus
// scoreboard of requested samples, a vector table for the underrun
// sequence, and hand-written corner-case sequences.
module tb_audio_sample_feeder;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int PL    = 8;

   logic          clk_50m = 1'b0;
   logic          rst;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          sample_req;
   logic [DW-1:0] wav_data;
   logic [AW:0]   level;
   logic          underrun;
   logic          underrun_clr;
   logic [3:0]    atten;

   always #10 clk_50m = ~clk_50m;

   audio_sample_feeder #(
      .DATA_W      (DW),
      .DEPTH       (DEPTH),
      .AW          (AW),
      .PRIME_LEVEL (PL)
   ) dut (
      .clk_50m      (clk_50m),
      .rst          (rst),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .sample_req   (sample_req),
      .wav_data     (wav_data),
      .level        (level),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .atten        (atten)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] exp_q[$];
   bit            m_run;
   bit            m_und;
   logic [DW-1:0] m_wav;

   typedef struct {
      bit            v;
      logic [DW-1:0] d;
      bit            req;
      bit            clr;
      int            lvl;
      bit            und;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      s_valid      = 1'b0;
      s_data       = '0;
      sample_req   = 1'b0;
      underrun_clr = 1'b0;
      repeat (2) @(posedge clk_50m);
      #1;
      rst = 1'b0;
      m_q.delete();
      exp_q.delete();
      m_run = 1'b0;
      m_und = 1'b0;
      m_wav = '0;
      chk("rst_level", level, 0);
      chk("rst_wav", wav_data, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_s_ready", s_ready, 1);
   endtask

   // One clock of stimulus; model advances, then DUT outputs are checked.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit req, input bit clr);
      int            sz;
      bit            acc;
      bit            nrun;
      logic [DW-1:0] e;
      sz           = m_q.size();
      s_valid      = v;
      s_data       = d;
      sample_req   = req;
      underrun_clr = clr;
      acc          = v && (sz != DEPTH);
      nrun         = m_run;
      if (clr) m_und = 1'b0;
      if (req) begin
         e = '0;
         if (m_run && sz != 0) begin
            e = m_q.pop_front();
`ifdef ATTEN_EN
            e = DW'($signed(e) >>> atten);
`endif
         end else if (m_run) begin
            m_und = 1'b1;
            nrun  = 1'b0;
         end
         exp_q.push_back(e);
         m_wav = e;
      end
      if (!m_run && sz >= PL) nrun = 1'b1;
      m_run = nrun;
      if (acc) m_q.push_back(d);
      @(posedge clk_50m);
      #1;
      s_valid      = 1'b0;
      sample_req   = 1'b0;
      underrun_clr = 1'b0;
      if (req) chk("wav_req", wav_data, exp_q.pop_front());
      else     chk("wav_hold", wav_data, m_wav);
      chk("level", level, m_q.size());
      chk("underrun", underrun, m_und);
      chk("s_ready", s_ready, (m_q.size() != DEPTH));
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      atten = 4'd0;
      do_reset();

      // FILL with no input: requests give silence, never underrun
      for (int k = 0; k < 3; k++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         repeat (1041) step(1'b0, '0, 1'b0, 1'b0);
      end

      // Prime with 8 words, then back-to-back requests
      for (int i = 0; i < 8; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("primed_last", wav_data, 16'h1007);

      // Underrun / clear / set-wins sequence, starting in RUN and empty
      tbl.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b1});
      tbl.push_back('{1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0});
      for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, i + 1, 1'b0});
      tbl.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 8, 1'b0});
      for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 7 - i, 1'b0});
      tbl.push_back('{1'b0, 16'h0, 1'b1, 1'b1, 0, 1'b1});
      tbl.push_back('{1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0});
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].req, tbl[i].clr);
         chk("tbl_level", level, tbl[i].lvl);
         chk("tbl_underrun", underrun, tbl[i].und);
      end

      // Fill to full with the mixer holding data while not ready
      idx = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_q.size() != DEPTH) begin
            step(1'b1, 16'h3000 + 16'(idx), 1'b0, 1'b0);
            idx++;
         end else begin
            step(1'b1, 16'h3000 + 16'(idx), 1'b0, 1'b0);
         end
      end
      chk("full_level", level, 16);
      chk("full_s_ready", s_ready, 0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("full_pop_wav", wav_data, 16'h3000);
      chk("full_pop_level", level, 15);
      chk("full_pop_s_ready", s_ready, 1);
      step(1'b1, 16'h3000 + 16'(idx), 1'b0, 1'b0);
      chk("refill_level", level, 16);

      // Simultaneous push and pop at level 5
      for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("lvl5", level, 5);
      step(1'b1, 16'h4000, 1'b1, 1'b0);
      chk("pushpop_level", level, 5);
      chk("pushpop_wav", wav_data, 16'h300C);

      // Attenuation
      while (m_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 16'h8000, 1'b0, 1'b0);
      step(1'b1, 16'h7FFF, 1'b0, 1'b0);
      step(1'b1, 16'h8000, 1'b0, 1'b0);
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      atten = 4'd2;
      step(1'b0, '0, 1'b1, 1'b0);
`ifdef ATTEN_EN
      chk("atten2_neg", wav_data, 16'hE000);
`else
      chk("atten2_neg", wav_data, 16'h8000);
`endif
      step(1'b0, '0, 1'b1, 1'b0);
`ifdef ATTEN_EN
      chk("atten2_pos", wav_data, 16'h1FFF);
`else
      chk("atten2_pos", wav_data, 16'h7FFF);
`endif
      atten = 4'd15;
      step(1'b0, '0, 1'b1, 1'b0);
      atten = 4'd0;
      step(1'b0, '0, 1'b1, 1'b0);
      chk("atten0", wav_data, 16'h1234);

      // Push while empty plus request in RUN: underrun, push lands
      step(1'b1, 16'h6000, 1'b1, 1'b0);
      chk("empty_push_req_und", underrun, 1);
      chk("empty_push_req_lvl", level, 1);
      chk("empty_push_req_wav", wav_data, 0);

      // Reset mid-stream discards buffered words
      step(1'b1, 16'h6001, 1'b0, 1'b1);
      step(1'b1, 16'h6002, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("post_reset_head", wav_data, 16'h5000);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
